mem_request_master: RTL and testbench

Core-side initiator for the 32-bit byte-addressed RAM request/acknowledge protocol. It accepts load/store commands from the Phaethon core, drives single-cycle read/write request pulses toward the RAM responder, waits for the matching acknowledge, and returns load data or completion status. Byte stores are performed as read-modify-write, because the responder always transfers 4 little-endian bytes starting at the given address.

---
 rtl/mem_request_master.sv | 139 +++++++++++++
 tb/tb_mem_request_master.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_request_master.sv
// Core-side initiator for the RAM request/acknowledge protocol.
// Byte stores are read-modify-write because the responder always moves a full 4-byte word.
module mem_request_master #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmdValid,
  output logic        cmdReady,
  input  logic        cmdWrite,
  input  logic        cmdByte,
  input  logic [31:0] cmdAddress,
  input  logic [31:0] cmdData,
  output logic        rspValid,
  output logic [31:0] rspData,
  output logic        rspError,
  output logic [31:0] ramAddress,
  output logic [31:0] ramOut,
  output logic        readReq,
  output logic        writeReq,
  input  logic [31:0] ramValue,
  input  logic        readAck,
  input  logic        writeAck
);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT
  } state_t;

  state_t      state, stateNext;
  logic [15:0] waitCount, waitCountNext;
  logic        isWrite, isWriteNext;
  logic        isByte, isByteNext;
  logic [31:0] ramAddressNext, ramOutNext, rspDataNext;
  logic        rspValidNext, rspErrorNext;
  logic        timeoutHit;

  // Request pulses and ready are decoded from state so they last exactly one state cycle.
  assign cmdReady   = (state == IDLE) && !reset;
  assign readReq    = (state == RD_REQ);
  assign writeReq   = (state == WR_REQ);
  // Asserted on the last permitted wait cycle; if no ack arrives in it the access aborts.
  assign timeoutHit = (32'(waitCount) == (TIMEOUT_CYCLES - 32'd1));

  always_comb begin
    stateNext      = state;
    waitCountNext  = waitCount;
    isWriteNext    = isWrite;
    isByteNext     = isByte;
    ramAddressNext = ramAddress;
    ramOutNext     = ramOut;
    rspDataNext    = rspData;
    rspValidNext   = 1'b0;
    rspErrorNext   = 1'b0;
    case (state)
      IDLE: begin
        if (cmdValid && cmdReady) begin
          isWriteNext    = cmdWrite;
          isByteNext     = cmdByte;
          ramAddressNext = cmdAddress;
          ramOutNext     = cmdData;
          stateNext      = (cmdWrite && !cmdByte) ? WR_REQ : RD_REQ;
        end
      end
      RD_REQ: begin
        waitCountNext = '0;
        stateNext     = RD_WAIT;
      end
      RD_WAIT: begin
        if (readAck) begin
          if (isWrite) begin
            // ramOut[7:0] still holds the store byte captured at accept.
            ramOutNext = {ramValue[31:8], ramOut[7:0]};
            stateNext  = WR_REQ;
          end else begin
            rspValidNext = 1'b1;
            rspDataNext  = isByte ? {24'b0, ramValue[7:0]} : ramValue;
            stateNext    = IDLE;
          end
        end else if (timeoutHit) begin
          rspValidNext = 1'b1;
          rspErrorNext = 1'b1;
          rspDataNext  = '0;
          stateNext    = IDLE;
        end else begin
          waitCountNext = waitCount + 16'd1;
        end
      end
      WR_REQ: begin
        waitCountNext = '0;
        stateNext     = WR_WAIT;
      end
      WR_WAIT: begin
        if (writeAck) begin
          rspValidNext = 1'b1;
          rspDataNext  = '0;
          stateNext    = IDLE;
        end else if (timeoutHit) begin
          rspValidNext = 1'b1;
          rspErrorNext = 1'b1;
          rspDataNext  = '0;
          stateNext    = IDLE;
        end else begin
          waitCountNext = waitCount + 16'd1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      waitCount  <= '0;
      isWrite    <= 1'b0;
      isByte     <= 1'b0;
      ramAddress <= '0;
      ramOut     <= '0;
      rspData    <= '0;
      rspValid   <= 1'b0;
      rspError   <= 1'b0;
    end else begin
      state      <= stateNext;
      waitCount  <= waitCountNext;
      isWrite    <= isWriteNext;
      isByte     <= isByteNext;
      ramAddress <= ramAddressNext;
      ramOut     <= ramOutNext;
      rspData    <= rspDataNext;
      rspValid   <= rspValidNext;
      rspError   <= rspErrorNext;
    end
  end

endmodule

// File: tb/tb_mem_request_master.sv
// Scoreboard bench for mem_request_master against a 2-cycle-ack RAM responder model.
module tb_mem_request_master;

  localparam int unsigned TMO = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmdValid = 1'b0;
  logic        cmdReady;
  logic        cmdWrite = 1'b0;
  logic        cmdByte = 1'b0;
  logic [31:0] cmdAddress = '0;
  logic [31:0] cmdData = '0;
  logic        rspValid;
  logic [31:0] rspData;
  logic        rspError;
  logic [31:0] ramAddress;
  logic [31:0] ramOut;
  logic        readReq;
  logic        writeReq;
  logic [31:0] ramValue = '0;
  logic        readAck = 1'b0;
  logic        writeAck = 1'b0;

  mem_request_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdWrite(cmdWrite), .cmdByte(cmdByte),
    .cmdAddress(cmdAddress), .cmdData(cmdData),
    .rspValid(rspValid), .rspData(rspData), .rspError(rspError),
    .ramAddress(ramAddress), .ramOut(ramOut), .readReq(readReq), .writeReq(writeReq),
    .ramValue(ramValue), .readAck(readAck), .writeAck(writeAck)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] wrq[$];
  int          tests = 0;
  int          fails = 0;
  int          cycCount = 0;
  int          rdCount = 0;
  int          wrCount = 0;
  logic        prevRd = 1'b0;
  logic        silent = 1'b0;
  logic        injectRdAck = 1'b0;
  logic [7:0]  mem [0:255];
  int          rdCnt = 0;
  int          wrCnt = 0;
  logic [7:0]  rdA = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    tests++;
    fails++;
    $display("FAIL %s", name);
  endtask

  always @(posedge clk) cycCount <= cycCount + 1;

  // Responder: captures a request, acks 2 cycles later (ack visible two cycles after the pulse).
  always @(posedge clk) begin
    readAck  <= 1'b0;
    writeAck <= 1'b0;
    if (rdCnt != 0) begin
      rdCnt <= rdCnt - 1;
      if (rdCnt == 1 && !silent) begin
        readAck  <= 1'b1;
        ramValue <= {mem[rdA + 8'd3], mem[rdA + 8'd2], mem[rdA + 8'd1], mem[rdA]};
      end
    end
    if (wrCnt != 0) begin
      wrCnt <= wrCnt - 1;
      if (wrCnt == 1 && !silent) writeAck <= 1'b1;
    end
    if (readReq) begin
      rdCnt <= 1;
      rdA   <= ramAddress[7:0];
    end
    if (writeReq) begin
      wrCnt <= 1;
      if (!silent) begin
        mem[ramAddress[7:0]]         <= ramOut[7:0];
        mem[ramAddress[7:0] + 8'd1]  <= ramOut[15:8];
        mem[ramAddress[7:0] + 8'd2]  <= ramOut[23:16];
        mem[ramAddress[7:0] + 8'd3]  <= ramOut[31:24];
      end
    end
    if (injectRdAck) begin
      readAck  <= 1'b1;
      ramValue <= 32'hBADBAD00;
    end
  end

  // Monitor: pops the scoreboard on every response and checks write data on every write pulse.
  always @(negedge clk) begin
    if (!reset) begin
      if (rspValid) begin
        if (sbq.size() == 0) begin
          failNow("unexpected rspValid");
        end else begin
          exp_t e;
          e = sbq.pop_front();
          if (!e.err) check("rspData", rspData, e.data);
          check("rspError", {31'b0, rspError}, {31'b0, e.err});
          check("rsp latency", cycCount, e.cyc);
        end
      end else if (rspError) begin
        failNow("rspError without rspValid");
      end
      if (writeReq) begin
        wrCount++;
        check("req overlap", {31'b0, readReq}, 32'd0);
        if (wrq.size() == 0) failNow("unexpected writeReq");
        else check("ramOut on writeReq", ramOut, wrq.pop_front());
      end
      if (readReq) begin
        rdCount++;
        check("readReq pulse width", {31'b0, prevRd}, 32'd0);
      end
      prevRd = readReq;
    end else begin
      prevRd = 1'b0;
    end
  end

  // Drive a command at a negedge and wait for acceptance; keep leaves cmdValid high.
  task automatic issue(input logic wr, input logic bt, input logic [31:0] addr,
                       input logic [31:0] data, input logic [31:0] expData,
                       input logic expErr, input int lat, input logic expect_,
                       input logic keep);
    int guard;
    cmdValid   = 1'b1;
    cmdWrite   = wr;
    cmdByte    = bt;
    cmdAddress = addr;
    cmdData    = data;
    guard = 0;
    while (!cmdReady && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!cmdReady) begin
      failNow("cmdReady timeout");
    end else if (expect_) begin
      exp_t e;
      e.data = expData;
      e.err  = expErr;
      e.cyc  = cycCount + lat;
      sbq.push_back(e);
    end
    @(negedge clk);
    if (!keep) cmdValid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sbq.size() != 0 && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    check("scoreboard drained", sbq.size(), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'h11; mem[8'h11] = 8'h22; mem[8'h12] = 8'h33; mem[8'h13] = 8'h44;
    mem[8'h30] = 8'h78; mem[8'h31] = 8'h56; mem[8'h32] = 8'h34; mem[8'h33] = 8'h12;

    repeat (3) @(negedge clk);
    check("reset cmdReady", {31'b0, cmdReady}, 32'd0);
    check("reset rspValid", {31'b0, rspValid}, 32'd0);
    check("reset rspData", rspData, 32'd0);
    check("reset ramAddress", ramAddress, 32'd0);
    check("reset ramOut", ramOut, 32'd0);
    check("reset reqs", {30'b0, readReq, writeReq}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("cmdReady after reset", {31'b0, cmdReady}, 32'd1);

    // word load, word store, load back, byte RMW store, byte load, unaligned load
    issue(1'b0, 1'b0, 32'h10, 32'h0, 32'h44332211, 1'b0, 4, 1'b1, 1'b0);
    drain();
    wrq.push_back(32'hDEADBEEF);
    issue(1'b1, 1'b0, 32'h20, 32'hDEADBEEF, 32'h0, 1'b0, 4, 1'b1, 1'b0);
    drain();
    issue(1'b0, 1'b0, 32'h20, 32'h0, 32'hDEADBEEF, 1'b0, 4, 1'b1, 1'b0);
    drain();
    wrq.push_back(32'h123456AB);
    issue(1'b1, 1'b1, 32'h30, 32'hFFFFFFAB, 32'h0, 1'b0, 7, 1'b1, 1'b0);
    drain();
    issue(1'b0, 1'b1, 32'h30, 32'h0, 32'h000000AB, 1'b0, 4, 1'b1, 1'b0);
    drain();
    issue(1'b0, 1'b0, 32'h31, 32'h0, 32'h00123456, 1'b0, 4, 1'b1, 1'b0);
    drain();

    // timeout on a load, then a stale ack must be ignored
    silent = 1'b1;
    issue(1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 1'b1, 2 + TMO, 1'b1, 1'b0);
    drain();
    check("cmdReady after timeout", {31'b0, cmdReady}, 32'd1);
    injectRdAck = 1'b1;
    @(negedge clk);
    injectRdAck = 1'b0;
    repeat (3) @(negedge clk);
    check("cmdReady after stale ack", {31'b0, cmdReady}, 32'd1);

    // timeout in the byte-store read phase issues no write
    issue(1'b1, 1'b1, 32'h30, 32'h000000CD, 32'h0, 1'b1, 2 + TMO, 1'b1, 1'b0);
    drain();
    silent = 1'b0;

    // reset while in RD_WAIT
    silent = 1'b1;
    issue(1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0, 0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid reset rspValid", {31'b0, rspValid}, 32'd0);
    check("mid reset cmdReady", {31'b0, cmdReady}, 32'd0);
    check("mid reset ramAddress", ramAddress, 32'd0);
    check("mid reset reqs", {30'b0, readReq, writeReq}, 32'd0);
    reset = 1'b0;
    silent = 1'b0;
    injectRdAck = 1'b1;
    @(negedge clk);
    injectRdAck = 1'b0;
    repeat (3) @(negedge clk);
    check("cmdReady after mid reset", {31'b0, cmdReady}, 32'd1);
    issue(1'b0, 1'b0, 32'h10, 32'h0, 32'h44332211, 1'b0, 4, 1'b1, 1'b0);
    drain();

    // back-to-back loads with cmdValid held high
    issue(1'b0, 1'b0, 32'h10, 32'h0, 32'h44332211, 1'b0, 4, 1'b1, 1'b1);
    issue(1'b0, 1'b0, 32'h20, 32'h0, 32'hDEADBEEF, 1'b0, 4, 1'b1, 1'b1);
    issue(1'b0, 1'b0, 32'h30, 32'h0, 32'h123456AB, 1'b0, 4, 1'b1, 1'b0);
    drain();
    repeat (4) @(negedge clk);

    check("total readReq pulses", rdCount, 32'd12);
    check("total writeReq pulses", wrCount, 32'd2);
    check("pending writes", wrq.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
